// File: rtl/recast_pkg.sv
// Shared types and widths for the Recast accumulator stage.
package recast_pkg;

    localparam int XIN_W = 4;
    localparam int SUM_W = 12;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/recast_accum.sv
// Frame accumulator: sums, max-tracks and counts samples from the upstream
// Recast stage, then holds the frame result until downstream takes it.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no samples in the current frame; SUM/MAXV/COUNT are 0
//   ST_ACCUM | partial frame, 1..FRAME_LEN-1 samples collected
//   ST_HOLD  | completed frame presented, input stalled until SUM_READY
module recast_accum
    import recast_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XIN_W-1:0] XIN,
    input  logic             XIN_VALID,
    output logic             XIN_READY,
    input  logic             FLUSH,
    output logic [SUM_W-1:0] SUM,
    output logic [XIN_W-1:0] MAXV,
    output logic [CNT_W-1:0] COUNT,
    output logic             SUM_VALID,
    input  logic             SUM_READY
);

    state_t           r_state;
    state_t           w_state_next;
    logic [SUM_W-1:0] r_sum;
    logic [XIN_W-1:0] r_maxv;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;
    logic             w_release;

    // Ready comes from state only; RST gating keeps it low while reset is held.
    assign XIN_READY  = (r_state != ST_HOLD) && !RST;
    assign w_accept   = XIN_VALID && XIN_READY;
    assign w_cnt_next = r_count + CNT_W'(1);
    assign w_last     = w_accept && (w_cnt_next == CNT_W'(FRAME_LEN));
    assign w_release  = (r_state == ST_HOLD) && SUM_READY;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a flush with no sample only closes a non-empty frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_last || FLUSH) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_last || FLUSH) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (SUM_READY) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Frame datapath; registers are zero in IDLE, so the first sample needs
    // no separate load path.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sum   <= '0;
            r_maxv  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_sum   <= r_sum + SUM_W'(XIN);
            r_maxv  <= (XIN > r_maxv) ? XIN : r_maxv;
            r_count <= w_cnt_next;
        end else if (w_release) begin
            r_sum   <= '0;
            r_maxv  <= '0;
            r_count <= '0;
        end
    end

    assign SUM       = r_sum;
    assign MAXV      = r_maxv;
    assign COUNT     = r_count;
    assign SUM_VALID = (r_state == ST_HOLD);

endmodule

// File: tb/tb_recast_accum.sv
// Bench for recast_accum: two instances (FRAME_LEN 8 and 255) share one
// stimulus stream and are each checked every cycle against a frame model.
module tb_recast_accum;

    localparam int FL0 = 8;
    localparam int FL1 = 255;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] XIN = '0;
    logic       XIN_VALID = 1'b0;
    logic       FLUSH = 1'b0;
    logic       SUM_READY = 1'b0;

    logic        rdy_o [2];
    logic [11:0] sum_o [2];
    logic [3:0]  max_o [2];
    logic [7:0]  cnt_o [2];
    logic        val_o [2];

    int n_vec = 0;
    int n_err = 0;

    // Model: contents of the current frame and whether it has been closed.
    int m_sum  [2] = '{0, 0};
    int m_max  [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    bit m_held [2] = '{0, 0};

    always #5 CLK = ~CLK;

    recast_accum #(.FRAME_LEN(FL0)) dut8 (
        .CLK(CLK), .RST(RST), .XIN(XIN), .XIN_VALID(XIN_VALID),
        .XIN_READY(rdy_o[0]), .FLUSH(FLUSH), .SUM(sum_o[0]), .MAXV(max_o[0]),
        .COUNT(cnt_o[0]), .SUM_VALID(val_o[0]), .SUM_READY(SUM_READY)
    );

    recast_accum #(.FRAME_LEN(FL1)) dut255 (
        .CLK(CLK), .RST(RST), .XIN(XIN), .XIN_VALID(XIN_VALID),
        .XIN_READY(rdy_o[1]), .FLUSH(FLUSH), .SUM(sum_o[1]), .MAXV(max_o[1]),
        .COUNT(cnt_o[1]), .SUM_VALID(val_o[1]), .SUM_READY(SUM_READY)
    );

    function automatic int frame_len(input int i);
        return (i == 0) ? FL0 : FL1;
    endfunction

    // Model update on each edge from the frame rules.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            int s, m, c;
            bit h;
            s = m_sum[i]; m = m_max[i]; c = m_cnt[i]; h = m_held[i];
            if (RST) begin
                s = 0; m = 0; c = 0; h = 0;
            end else if (h) begin
                if (SUM_READY) begin
                    s = 0; m = 0; c = 0; h = 0;
                end
            end else begin
                if (XIN_VALID) begin
                    s = s + int'(XIN);
                    if (int'(XIN) > m) m = int'(XIN);
                    c = c + 1;
                end
                if ((XIN_VALID && c == frame_len(i)) || (FLUSH && c > 0)) h = 1;
            end
            m_sum[i]  <= s;
            m_max[i]  <= m;
            m_cnt[i]  <= c;
            m_held[i] <= h;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            string nm;
            nm = (i == 0) ? "dut8" : "dut255";
            cmp({nm, ".SUM"},       int'(sum_o[i]), RST ? 0 : m_sum[i]);
            cmp({nm, ".MAXV"},      int'(max_o[i]), RST ? 0 : m_max[i]);
            cmp({nm, ".COUNT"},     int'(cnt_o[i]), RST ? 0 : m_cnt[i]);
            cmp({nm, ".SUM_VALID"}, int'(val_o[i]), (!RST && m_held[i]) ? 1 : 0);
            cmp({nm, ".XIN_READY"}, int'(rdy_o[i]), (!RST && !m_held[i]) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        XIN_VALID = 1'b0; FLUSH = 1'b0; SUM_READY = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic send(input int x, input bit fl);
        XIN = 4'(x); XIN_VALID = 1'b1; FLUSH = fl;
        tick();
        XIN_VALID = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        // Reset state, checked while RST is held.
        tick();
        cmp("rst.SUM", int'(sum_o[0]), 0);
        cmp("rst.COUNT", int'(cnt_o[0]), 0);
        cmp("rst.XIN_READY", int'(rdy_o[0]), 0);
        cmp("rst.SUM_VALID", int'(val_o[1]), 0);
        do_reset();

        // Full frame of 15s, back to back.
        XIN = 4'd15; XIN_VALID = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) cmp("full.valid_before_last", int'(val_o[0]), 0);
        end
        XIN_VALID = 1'b0;
        cmp("full.SUM", int'(sum_o[0]), 120);
        cmp("full.MAXV", int'(max_o[0]), 15);
        cmp("full.COUNT", int'(cnt_o[0]), 8);
        cmp("full.SUM_VALID", int'(val_o[0]), 1);
        cmp("full.model_sum", m_sum[0], 120);
        cmp("full.dut255_partial", int'(cnt_o[1]), 8);

        // Backpressure: held result stays put and input stays stalled.
        XIN = 4'd3; XIN_VALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            cmp("bp.SUM", int'(sum_o[0]), 120);
            cmp("bp.SUM_VALID", int'(val_o[0]), 1);
            cmp("bp.XIN_READY", int'(rdy_o[0]), 0);
        end
        XIN_VALID = 1'b0;
        SUM_READY = 1'b1;
        tick();
        SUM_READY = 1'b0;
        cmp("rel.SUM_VALID", int'(val_o[0]), 0);
        cmp("rel.SUM", int'(sum_o[0]), 0);
        cmp("rel.COUNT", int'(cnt_o[0]), 0);
        cmp("rel.XIN_READY", int'(rdy_o[0]), 1);

        // Flush in IDLE with no sample is ignored.
        do_reset();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        cmp("idleflush.SUM_VALID", int'(val_o[0]), 0);

        // Flush after 1,2,3.
        send(1, 0); send(2, 0); send(3, 0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        cmp("flush.SUM", int'(sum_o[0]), 6);
        cmp("flush.MAXV", int'(max_o[0]), 3);
        cmp("flush.COUNT", int'(cnt_o[0]), 3);
        cmp("flush.SUM_VALID", int'(val_o[1]), 1);

        // Flush together with a sample after 4,4.
        do_reset();
        send(4, 0); send(4, 0); send(9, 1);
        cmp("flushs.SUM", int'(sum_o[0]), 17);
        cmp("flushs.MAXV", int'(max_o[0]), 9);
        cmp("flushs.COUNT", int'(cnt_o[0]), 3);
        cmp("flushs.model_sum", m_sum[1], 17);

        // Widest frame.
        do_reset();
        XIN = 4'd15; XIN_VALID = 1'b1;
        for (int k = 0; k < 255; k++) tick();
        XIN_VALID = 1'b0;
        cmp("wide.SUM", int'(sum_o[1]), 3825);
        cmp("wide.COUNT", int'(cnt_o[1]), 255);
        cmp("wide.SUM_VALID", int'(val_o[1]), 1);
        cmp("wide.model_sum", m_sum[1], 3825);

        // Reset mid-frame, then a frame of 2s.
        do_reset();
        for (int k = 0; k < 5; k++) send(7, 0);
        RST = 1'b1;
        #1;
        cmp("midrst.SUM", int'(sum_o[0]), 0);
        cmp("midrst.COUNT", int'(cnt_o[0]), 0);
        cmp("midrst.MAXV", int'(max_o[0]), 0);
        cmp("midrst.XIN_READY", int'(rdy_o[0]), 0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 8; k++) send(2, 0);
        cmp("after.SUM", int'(sum_o[0]), 16);
        cmp("after.SUM_VALID", int'(val_o[0]), 1);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            XIN       = 4'($urandom_range(15));
            XIN_VALID = ($urandom_range(99) < 70);
            FLUSH     = ($urandom_range(99) < 8);
            SUM_READY = ($urandom_range(99) < 40);
            RST       = ($urandom_range(299) == 0);
            tick();
        end
        RST = 1'b0; XIN_VALID = 1'b0; FLUSH = 1'b0; SUM_READY = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/recast_accum.md
RECAST_ACCUM -- requirements
Module: recast_accum

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, giving the number of samples per frame (legal range 1..255).
REQ-002 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port XIN, input, 4 bits: unsigned sample from the upstream Recast stage (its XOUT).
REQ-005 SHALL have port XIN_VALID, input, 1 bit: XIN holds a valid sample.
REQ-006 SHALL have port XIN_READY, output, 1 bit: block can accept a sample this cycle.
REQ-007 SHALL have port FLUSH, input, 1 bit: close the current partial frame early.
REQ-008 SHALL have port SUM, output, 12 bits: unsigned frame sum.
REQ-009 SHALL have port MAXV, output, 4 bits: largest sample in the frame.
REQ-010 SHALL have port COUNT, output, 8 bits: samples in the current or held frame.
REQ-011 SHALL have port SUM_VALID, output, 1 bit: SUM, MAXV and COUNT hold a completed frame.
REQ-012 SHALL have port SUM_READY, input, 1 bit: downstream accepts the result.

Function
REQ-013 SHALL implement FSM states IDLE (no samples), ACCUM (partial frame), HOLD (result presented).
REQ-014 SHALL accept a sample only on a cycle where XIN_VALID=1 and XIN_READY=1.
REQ-015 SHALL drive XIN_READY=1 in IDLE and ACCUM and 0 in HOLD, decoded from state with no dependency on XIN_VALID.
REQ-016 SHALL, on a sample accepted in IDLE, load SUM=XIN, MAXV=XIN, COUNT=1 and go to ACCUM; if FRAME_LEN=1, go to HOLD instead.
REQ-017 SHALL, on a sample accepted in ACCUM, apply SUM+=XIN (zero-extended to 12 bits), MAXV=max(MAXV,XIN), COUNT+=1.
REQ-018 SHALL go from ACCUM to HOLD when COUNT reaches FRAME_LEN, with SUM_VALID=1 on the first clock edge after the last sample (latency 1 cycle).
REQ-019 SHALL never overflow SUM: 15*255=3825 fits in 12 bits, so no saturation logic is needed.
REQ-020 SHALL, on FLUSH=1 in ACCUM, go to HOLD; a sample accepted in the same cycle is included first.
REQ-021 SHALL, on FLUSH=1 in IDLE with a sample accepted, treat it as a one-sample frame and go to HOLD; FLUSH in IDLE with no sample, or FLUSH in HOLD, SHALL be ignored.
REQ-022 SHALL, in HOLD, keep SUM, MAXV, COUNT and SUM_VALID stable until SUM_READY=1.
REQ-023 SHALL, on HOLD with SUM_READY=1, go to IDLE, clear SUM, MAXV and COUNT to 0, and deassert SUM_VALID the next cycle (no same-cycle restart).
REQ-024 SHALL drive SUM_VALID only from the registered state (no combinational path from SUM_READY).

Reset
REQ-025 SHALL, while RST=1, force state IDLE and drive SUM=0, MAXV=0, COUNT=0, SUM_VALID=0, XIN_READY=0.
REQ-026 SHALL discard any partial or held frame on reset mid-operation; the first sample after RST falls starts a new frame.

Structure
REQ-027 SHALL take the state enum, SUM width (12) and COUNT width (8) from the shared package (recast_pkg).
REQ-028 SHALL be one flat module; the max-tracker is inline logic, not a sub-module.

Verification
REQ-029 SHALL cover: FRAME_LEN=8, eight samples of 15 back-to-back -> SUM=120, MAXV=15, COUNT=8, SUM_VALID one cycle after the 8th sample.
REQ-030 SHALL cover backpressure: SUM_READY held 0 for 5 cycles in HOLD -> outputs stable, XIN_READY=0; SUM_READY=1 -> IDLE next cycle.
REQ-031 SHALL cover flush: samples 1,2,3 then FLUSH=1 -> SUM=6, MAXV=3, COUNT=3.
REQ-032 SHALL cover flush with a sample: FLUSH=1 together with sample 9 after samples 4,4 -> SUM=17, MAXV=9, COUNT=3.
REQ-033 SHALL cover the widest frame: FRAME_LEN=255, all samples 15 -> SUM=3825, no wrap.
REQ-034 SHALL cover reset mid-frame: RST pulsed after 5 of 8 samples -> all outputs 0; the next full frame of 2s -> SUM=16.
